// File: rtl/ghost_mover.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ghost_mover: moves one ghost one maze tile per move_tick, choosing  |
// | a legal non-reversing heading from fetched wall flags. Rev 1.0      |
// +--------------------------------------------------------------------+
module ghost_mover #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int X_MAX   = 27,
  parameter int START_X = 13,
  parameter int START_Y = 11,
  parameter int START_D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           move_tick,
  input  logic [1:0]     rand_dir,
  output logic           wall_req,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  input  logic           wall_valid,
  input  logic [3:0]     walls,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic           busy,
  output logic           step_done,
  output logic           stuck
);

  localparam logic [X_W-1:0] C_X_MAX   = X_W'(X_MAX);
  localparam logic [X_W-1:0] C_START_X = X_W'(START_X);
  localparam logic [Y_W-1:0] C_START_Y = Y_W'(START_Y);
  localparam logic [1:0]     C_START_D = 2'(START_D);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_QUERY  = 2'd1,
    S_CHOOSE = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_walls;
  logic [1:0]     r_cand;
  logic [1:0]     r_dir;
  logic [2:0]     r_tries;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_wall_req;
  logic           r_step_done;
  logic           r_stuck;

  logic [1:0]     w_rev;
  logic           w_cand_ok;
  logic           w_rev_open;
  logic           w_exhausted;
  logic [X_W-1:0] w_nx;
  logic [Y_W-1:0] w_ny;

  assign w_rev       = r_dir ^ 2'b10;
  assign w_cand_ok   = !r_walls[r_cand] && (r_cand != w_rev);
  assign w_rev_open  = !r_walls[w_rev];
  assign w_exhausted = (r_tries == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (move_tick) w_next = S_QUERY;
      S_QUERY:  if (wall_valid) w_next = S_CHOOSE;
      S_CHOOSE: begin
        if (w_exhausted)    w_next = w_rev_open ? S_STEP : S_IDLE;
        else if (w_cand_ok) w_next = S_STEP;
      end
      S_STEP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Horizontal tunnel wraps between column 0 and X_MAX; rows wrap only by overflow.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (r_dir)
      2'd0: w_ny = r_y - 1'b1;
      2'd1: w_nx = (r_x == C_X_MAX) ? '0 : r_x + 1'b1;
      2'd2: w_ny = r_y + 1'b1;
      2'd3: w_nx = (r_x == '0) ? C_X_MAX : r_x - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_walls     <= '0;
      r_cand      <= '0;
      r_dir       <= C_START_D;
      r_tries     <= '0;
      r_x         <= C_START_X;
      r_y         <= C_START_Y;
      r_wall_req  <= 1'b0;
      r_step_done <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_wall_req  <= (w_next == S_QUERY);
      r_step_done <= (r_state == S_STEP);
      r_stuck     <= (r_state == S_CHOOSE) && w_exhausted && !w_rev_open;
      case (r_state)
        S_QUERY: begin
          if (wall_valid) begin
            r_walls <= walls;
            r_cand  <= rand_dir;
            r_tries <= '0;
          end
        end
        S_CHOOSE: begin
          if (w_exhausted) begin
            if (w_rev_open) r_dir <= w_rev;
          end else if (w_cand_ok) begin
            r_dir <= r_cand;
          end else begin
            r_cand  <= r_cand + 2'd1;
            r_tries <= r_tries + 3'd1;
          end
        end
        S_STEP: begin
          r_x <= w_nx;
          r_y <= w_ny;
        end
        default: ;
      endcase
    end
  end

  assign wall_req  = r_wall_req;
  assign wall_x    = r_x;
  assign wall_y    = r_y;
  assign pos_x     = r_x;
  assign pos_y     = r_y;
  assign dir       = r_dir;
  assign busy      = (r_state != S_IDLE);
  assign step_done = r_step_done;
  assign stuck     = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_ghost_mover.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ghost_mover: directed table, corner sequences and randomized     |
// | moves against a rule-level ghost model. Rev 1.0                    |
// +--------------------------------------------------------------------+
module tb_ghost_mover;

  localparam int X_W   = 5;
  localparam int Y_W   = 5;
  localparam int X_MAX = 27;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           move_tick;
  logic [1:0]     rand_dir;
  logic           wall_req;
  logic [X_W-1:0] wall_x;
  logic [Y_W-1:0] wall_y;
  logic           wall_valid;
  logic [3:0]     walls;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic [1:0]     dir;
  logic           busy;
  logic           step_done;
  logic           stuck;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_d;

  ghost_mover #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX),
    .START_X(13), .START_Y(11), .START_D(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .move_tick(move_tick), .rand_dir(rand_dir),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_valid(wall_valid), .walls(walls),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .busy(busy),
    .step_done(step_done), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] w;
    logic [1:0] r;
    int         ed;
    int         ex;
    int         ey;
    bit         est;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Rule-level reference: try rand, rand+1, ... skipping blocked sides and the
  // reverse heading; fall back to reversing; otherwise the ghost is stuck.
  function automatic void ref_choose(input logic [3:0] w, input int d, input int r,
                                     output int nd, output bit stk);
    int back;
    int c;
    back = d ^ 2;
    stk  = 1'b0;
    nd   = d;
    for (int k = 0; k < 4; k++) begin
      c = (r + k) % 4;
      if (!w[c] && c != back) begin
        nd = c;
        return;
      end
    end
    if (!w[back]) nd = back;
    else          stk = 1'b1;
  endfunction

  task automatic do_move(input string name, input logic [3:0] w, input logic [1:0] r,
                         input int dly, input bit spur, input bit noise,
                         input int ex, input int ey, input int ed, input bit est);
    int nstep, nstuck, reqc, cyc, tail;
    bit served, pos_moved, wxy_bad, done;
    int x0, y0;
    x0 = pos_x; y0 = pos_y;
    nstep = 0; nstuck = 0; reqc = 0; cyc = 0; tail = 0;
    served = 0; pos_moved = 0; wxy_bad = 0; done = 0;
    @(negedge clk);
    move_tick = 1'b1; rand_dir = r; walls = w;
    @(negedge clk);
    move_tick = 1'b0;
    while (!done && cyc < 200) begin
      if (wall_x != pos_x || wall_y != pos_y) wxy_bad = 1;
      nstep  += int'(step_done);
      nstuck += int'(stuck);
      wall_valid = 1'b0;
      move_tick  = 1'b0;
      if (wall_req) begin
        reqc++;
        if (int'(pos_x) != x0 || int'(pos_y) != y0) pos_moved = 1;
        if (reqc == dly + 1) begin
          wall_valid = 1'b1;
          walls      = w;
          served     = 1;
        end
      end else if (served) begin
        walls = 4'($urandom);
        if (noise && busy) wall_valid = 1'($urandom);
      end
      if (spur && busy && cyc[0]) move_tick = 1'b1;
      if (served && !busy && (nstep + nstuck) > 0) tail++;
      if (tail == 3) done = 1;
      cyc++;
      if (!done) @(negedge clk);
    end
    wall_valid = 1'b0;
    move_tick  = 1'b0;
    chk({name, " completes"}, int'(done), 1);
    chk({name, " wall_req cycles"}, reqc, dly + 1);
    chk({name, " step_done count"}, nstep, est ? 0 : 1);
    chk({name, " stuck count"}, nstuck, est ? 1 : 0);
    chk({name, " pos_x"}, int'(pos_x), ex);
    chk({name, " pos_y"}, int'(pos_y), ey);
    chk({name, " dir"}, int'(dir), ed);
    chk({name, " pos stable in query"}, int'(pos_moved), 0);
    chk({name, " wall_xy tracks pos"}, int'(wxy_bad), 0);
    m_x = ex; m_y = ey; m_d = ed;
  endtask

  task automatic model_move(input string name, input logic [3:0] w, input logic [1:0] r,
                            input int dly, input bit spur, input bit noise);
    int nd, nx, ny;
    bit stk;
    ref_choose(w, m_d, int'(r), nd, stk);
    nx = m_x; ny = m_y;
    if (!stk) begin
      case (nd)
        0: ny = (m_y + 31) % 32;
        1: nx = (m_x + 1) % (X_MAX + 1);
        2: ny = (m_y + 1) % 32;
        default: nx = (m_x + X_MAX) % (X_MAX + 1);
      endcase
    end
    do_move(name, w, r, dly, spur, noise, nx, ny, nd, stk);
  endtask

  initial begin
    tbl[0] = '{4'b0000, 2'd1, 2, 13, 12, 1'b0};  // open tile, reverse skipped
    tbl[1] = '{4'b1101, 2'd0, 1, 14, 12, 1'b0};  // only right open
    tbl[2] = '{4'b0101, 2'd0, 1, 15, 12, 1'b0};  // horizontal corridor
    tbl[3] = '{4'b0111, 2'd2, 3, 14, 12, 1'b0};  // dead end, reverse taken
    tbl[4] = '{4'b1111, 2'd0, 3, 14, 12, 1'b1};  // fully blocked
    tbl[5] = '{4'b0000, 2'd3, 3, 13, 12, 1'b0};
    tbl[6] = '{4'b1010, 2'd1, 2, 13, 13, 1'b0};
    tbl[7] = '{4'b0000, 2'd0, 1, 14, 13, 1'b0};

    rst_n = 1'b0; move_tick = 1'b0; rand_dir = 2'd0; wall_valid = 1'b0; walls = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset pos_x", int'(pos_x), 13);
    chk("reset pos_y", int'(pos_y), 11);
    chk("reset dir", int'(dir), 3);
    chk("reset busy", int'(busy), 0);
    chk("reset wall_req", int'(wall_req), 0);
    chk("reset step_done", int'(step_done), 0);
    chk("reset stuck", int'(stuck), 0);
    rst_n = 1'b1;
    m_x = 13; m_y = 11; m_d = 3;

    // Move away from start, then reset asynchronously while a request is pending.
    do_move("pre-reset up", 4'b1110, 2'd0, 0, 0, 0, 13, 10, 0, 0);
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk);
    chk("query wall_req", int'(wall_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset wall_req", int'(wall_req), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset pos_x", int'(pos_x), 13);
    chk("async reset pos_y", int'(pos_y), 11);
    chk("async reset dir", int'(dir), 3);
    @(negedge clk); rst_n = 1'b1;
    m_x = 13; m_y = 11; m_d = 3;

    for (int i = 0; i < 8; i++) begin
      do_move($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, i % 3, 0, 0,
              tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].est);
    end

    // Walk to the right tunnel mouth at (27,14).
    do_move("to row 14", 4'b1011, 2'd0, 0, 0, 0, 14, 14, 2, 0);
    for (int i = 0; i < 13; i++) begin
      do_move($sformatf("east%0d", i), 4'b1101, 2'd0, 0, 0, 0, 15 + i, 14, 1, 0);
    end
    do_move("tunnel right", 4'b0101, 2'd0, 1, 0, 0, 0, 14, 1, 0);
    do_move("tunnel left", 4'b0111, 2'd0, 0, 0, 0, 27, 14, 3, 0);
    do_move("handshake delay7", 4'b0101, 2'd3, 7, 1, 0, 26, 14, 3, 0);

    for (int i = 0; i < 200; i++) begin
      model_move($sformatf("rnd%0d", i), 4'($urandom), 2'($urandom),
                 int'($urandom_range(0, 5)), 1'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
